// File: rtl/sensor_trigger_dispatcher_if.sv
// Trigger/ack bus between the timing manager, the sensor dispatcher and the sensor interfaces.
interface sensor_trigger_dispatcher_if #(
  parameter int unsigned N_SENSORS = 10,
  parameter int unsigned TIMEOUT_W = 16
);
  logic                 trigger;
  logic [N_SENSORS-1:0] en_bits;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic [N_SENSORS-1:0] sensor_ack;
  logic                 clear_timeout_flags;
  logic [N_SENSORS-1:0] sensor_start;
  logic [N_SENSORS-1:0] done;
  logic [N_SENSORS-1:0] timeout_flags;
  logic                 busy;
  logic [7:0]           overrun_count;

  modport master (
    output trigger, en_bits, timeout_cycles, sensor_ack, clear_timeout_flags,
    input  sensor_start, done, timeout_flags, busy, overrun_count
  );

  modport slave (
    input  trigger, en_bits, timeout_cycles, sensor_ack, clear_timeout_flags,
    output sensor_start, done, timeout_flags, busy, overrun_count
  );
endinterface

// File: rtl/sensor_trigger_dispatcher.sv
// Fans a trigger out to enabled sensors and tracks each until ack or timeout.
// Optional overrun counter: define SENSOR_DISPATCH_OVERRUN_CNT_EN.
module sensor_trigger_dispatcher #(
  parameter int unsigned N_SENSORS = 10,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic clk,
  input  logic rst,
  sensor_trigger_dispatcher_if.slave bus
);

  localparam int unsigned OVR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q [N_SENSORS];
  state_e               state_d [N_SENSORS];
  logic [TIMEOUT_W-1:0] cnt_q   [N_SENSORS];
  logic [TIMEOUT_W-1:0] cnt_d   [N_SENSORS];

  logic [N_SENSORS-1:0] start_q, start_d;
  logic [N_SENSORS-1:0] done_q,  done_d;
  logic [N_SENSORS-1:0] flags_q, flags_d;
  logic [N_SENSORS-1:0] flag_set;
  logic                 busy_q,  busy_d;
  logic [TIMEOUT_W-1:0] tc_last;
  logic                 tc_en;

  assign tc_en   = (bus.timeout_cycles != '0);
  assign tc_last = bus.timeout_cycles - TIMEOUT_W'(1);

  // Per-channel state registers plus registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      start_q <= '0;
      done_q  <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_SENSORS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      start_q <= start_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state for every channel; disable beats trigger, ack beats timeout.
  always_comb begin
    for (int i = 0; i < N_SENSORS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    flag_set = '0;
    start_d  = '0;
    done_d   = '0;
    busy_d   = 1'b0;

    for (int i = 0; i < N_SENSORS; i++) begin
      if (!bus.en_bits[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else if (bus.trigger && (state_q[i] != START)) begin
        state_d[i] = START;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE:  state_d[i] = IDLE;
          START: begin
            state_d[i] = WAIT;
            cnt_d[i]   = '0;
          end
          WAIT: begin
            if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + TIMEOUT_W'(1);
            if (bus.sensor_ack[i]) begin
              state_d[i] = DONE;
            end else if (tc_en && (cnt_q[i] == tc_last)) begin
              state_d[i]  = DONE;
              flag_set[i] = 1'b1;
            end
          end
          DONE:    state_d[i] = DONE;
          default: state_d[i] = IDLE;
        endcase
      end

      start_d[i] = (state_d[i] == START);
      done_d[i]  = (state_d[i] == DONE);
      if ((state_d[i] == START) || (state_d[i] == WAIT)) busy_d = 1'b1;
    end

    // A new timeout on the same bit outranks the clear pulse.
    flags_d = (flags_q & ~{N_SENSORS{bus.clear_timeout_flags}}) | flag_set;
  end

`ifdef SENSOR_DISPATCH_OVERRUN_CNT_EN
  logic [N_SENSORS-1:0] wait_en;
  logic                 overrun_hit;
  logic [OVR_W-1:0]     ovr_q;

  always_comb begin
    wait_en = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      wait_en[i] = (state_q[i] == WAIT) && bus.en_bits[i];
    end
    overrun_hit = bus.trigger && (wait_en != '0);
  end

  // Saturating count of triggers landing on an in-flight wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (overrun_hit && (ovr_q != '1)) begin
      ovr_q <= ovr_q + OVR_W'(1);
    end
  end

  assign bus.overrun_count = ovr_q;
`else
  assign bus.overrun_count = OVR_W'(0);
`endif

  assign bus.sensor_start  = start_q;
  assign bus.done          = done_q;
  assign bus.timeout_flags = flags_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_sensor_trigger_dispatcher.sv
// Directed bench for sensor_trigger_dispatcher: dispatch, timeout, tie, overrun, enable drop, reset.
module tb_sensor_trigger_dispatcher;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

`ifdef SENSOR_DISPATCH_OVERRUN_CNT_EN
  localparam logic [31:0] OVR_ONE = 32'd1;
  localparam logic [31:0] OVR_SAT = 32'd255;
`else
  localparam logic [31:0] OVR_ONE = 32'd0;
  localparam logic [31:0] OVR_SAT = 32'd0;
`endif

  sensor_trigger_dispatcher_if #(.N_SENSORS(10), .TIMEOUT_W(16)) bus ();

  sensor_trigger_dispatcher #(.N_SENSORS(10), .TIMEOUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst                     = 1'b1;
    bus.trigger             = 1'b0;
    bus.en_bits             = '0;
    bus.timeout_cycles      = '0;
    bus.sensor_ack          = '0;
    bus.clear_timeout_flags = 1'b0;
    steps(2);
    chk("rst_start", 32'(bus.sensor_start), 32'h0);
    chk("rst_done",  32'(bus.done),         32'h0);
    chk("rst_flags", 32'(bus.timeout_flags), 32'h0);
    chk("rst_busy",  32'(bus.busy),         32'h0);
    chk("rst_ovr",   32'(bus.overrun_count), 32'h0);
    rst = 1'b0;

    // Basic dispatch on channel 0, ack at T+10
    bus.en_bits = 10'h001; bus.timeout_cycles = 16'd100;
    step();
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+1
    chk("basic_start_t1", 32'(bus.sensor_start), 32'h001);
    chk("basic_done_t1",  32'(bus.done),         32'h000);
    chk("basic_busy_t1",  32'(bus.busy),         32'h1);
    step();                                                      // T+2
    chk("basic_start_t2", 32'(bus.sensor_start), 32'h000);
    steps(8);                                                    // T+10
    chk("basic_done_t10", 32'(bus.done), 32'h000);
    chk("basic_busy_t10", 32'(bus.busy), 32'h1);
    bus.sensor_ack = 10'h001; step(); bus.sensor_ack = '0;       // T+11
    chk("basic_done_t11",  32'(bus.done),          32'h001);
    chk("basic_flags_t11", 32'(bus.timeout_flags), 32'h000);
    chk("basic_busy_t11",  32'(bus.busy),          32'h0);

    // Timeout on channel 2 with 5-cycle limit
    bus.en_bits = 10'h004; bus.timeout_cycles = 16'd5;
    step();
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+1
    chk("to_start_t1", 32'(bus.sensor_start), 32'h004);
    steps(5);                                                    // T+6
    chk("to_done_t6",  32'(bus.done),          32'h000);
    chk("to_flags_t6", 32'(bus.timeout_flags), 32'h000);
    step();                                                      // T+7
    chk("to_done_t7",  32'(bus.done),          32'h004);
    chk("to_flags_t7", 32'(bus.timeout_flags), 32'h004);
    bus.clear_timeout_flags = 1'b1; step(); bus.clear_timeout_flags = 1'b0;
    chk("to_flags_clr", 32'(bus.timeout_flags), 32'h000);
    chk("to_done_clr",  32'(bus.done),          32'h004);

    // Ack on the last wait cycle beats the timeout
    bus.timeout_cycles = 16'd4;
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+1
    chk("tie_start_t1", 32'(bus.sensor_start), 32'h004);
    steps(4);                                                    // T+5
    chk("tie_done_t5", 32'(bus.done), 32'h000);
    bus.sensor_ack = 10'h004; step(); bus.sensor_ack = '0;       // T+6
    chk("tie_done_t6",  32'(bus.done),          32'h004);
    chk("tie_flags_t6", 32'(bus.timeout_flags), 32'h000);

    // Overrun: retrigger channels 0/1 mid-wait
    bus.en_bits = 10'h003; bus.timeout_cycles = 16'd100;
    step();
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+1
    chk("ovr_start_t1", 32'(bus.sensor_start), 32'h003);
    steps(3);                                                    // T+4
    chk("ovr_start_t4", 32'(bus.sensor_start), 32'h000);
    chk("ovr_busy_t4",  32'(bus.busy),         32'h1);
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+5
    chk("ovr_start_t5", 32'(bus.sensor_start), 32'h003);
    chk("ovr_count_1",  32'(bus.overrun_count), OVR_ONE);
    for (int n = 0; n < 300; n++) begin
      step();
      bus.trigger = 1'b1; step(); bus.trigger = 1'b0;
    end
    chk("ovr_count_sat", 32'(bus.overrun_count), OVR_SAT);

    // Enable drop mid-wait on channel 1
    bus.en_bits = 10'h002;
    step();
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+1
    chk("en_start_t1", 32'(bus.sensor_start), 32'h002);
    steps(2);                                                    // T+3
    chk("en_busy_t3", 32'(bus.busy), 32'h1);
    bus.en_bits = 10'h000; step();                               // T+4
    chk("en_done_t4",  32'(bus.done),         32'h000);
    chk("en_busy_t4",  32'(bus.busy),         32'h0);
    bus.sensor_ack = 10'h002; step(); bus.sensor_ack = '0;
    step();
    chk("en_ack_ignored_done", 32'(bus.done),         32'h000);
    chk("en_ack_ignored_busy", 32'(bus.busy),         32'h0);
    chk("en_no_start",         32'(bus.sensor_start), 32'h000);

    // Reset mid-wait, then a clean dispatch
    bus.en_bits = 10'h003;
    step();
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+1
    steps(2);                                                    // T+3
    rst = 1'b1; step(); rst = 1'b0;                              // T+4
    chk("rstm_start", 32'(bus.sensor_start),  32'h0);
    chk("rstm_done",  32'(bus.done),          32'h0);
    chk("rstm_flags", 32'(bus.timeout_flags), 32'h0);
    chk("rstm_busy",  32'(bus.busy),          32'h0);
    chk("rstm_ovr",   32'(bus.overrun_count), 32'h0);
    steps(2);                                                    // T+6
    bus.trigger = 1'b1; step(); bus.trigger = 1'b0;              // T+7
    chk("rstm_start_t7", 32'(bus.sensor_start), 32'h003);
    chk("rstm_busy_t7",  32'(bus.busy),         32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
